// File: rtl/gnn_0_bias_loader_mb.sv
// Bias loader: decodes one instruction, starts a DRAM read and writes the
// returned stream beats into one (or all) buffer banks, flagging overrun/short streams.
module gnn_0_bias_loader_mb #(
  parameter int INST_LENGTH     = 96,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int XFER_SIZE_WIDTH = 32,
  parameter int BUF_AW          = 9,
  parameter int NUM_BANKS       = 4
) (
  input  logic                       kernel_clk,
  input  logic                       kernel_rst,
  input  logic                       ap_start,
  output logic                       ap_done,
  input  logic [ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [INST_LENGTH-1:0]     ctrl_instruction,
  output logic [ADDR_WIDTH-1:0]      dram_xfer_start_addr,
  output logic [XFER_SIZE_WIDTH-1:0] dram_xfer_size_in_bytes,
  output logic                       read_start,
  input  logic                       read_done,
  input  logic                       data_tvalid,
  output logic                       data_tready,
  input  logic                       data_tlast,
  input  logic [DATA_WIDTH-1:0]      data_tdata,
  output logic [NUM_BANKS-1:0]       buf_wr_valid,
  output logic [BUF_AW-1:0]          buf_wr_addr,
  output logic [DATA_WIDTH-1:0]      buf_wr_data,
  output logic [1:0]                 err_status
);

  localparam int BW = $clog2(NUM_BANKS);

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, STREAM, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                buf_start_q, buf_start_d;
  logic [15:0]                len_q, len_d;
  logic [15:0]                beat_q, beat_d;
  logic [BW-1:0]              bank_q, bank_d;
  logic                       bcast_q, bcast_d;
  logic                       rd_seen_q, rd_seen_d;
  logic [1:0]                 err_q, err_d;
  logic [ADDR_WIDTH-1:0]      xaddr_q, xaddr_d;
  logic [XFER_SIZE_WIDTH-1:0] xsize_q, xsize_d;
  logic                       read_start_q, read_start_d;
  logic                       ap_done_q, ap_done_d;
  logic [NUM_BANKS-1:0]       wr_valid_q, wr_valid_d;
  logic [BUF_AW-1:0]          wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;

  logic                       hs;
  logic                       rd_any;
  logic                       last_beat;
  logic [15:0]                addr_sum;
  logic [NUM_BANKS-1:0]       bank_mask;

  assign data_tready = (state_q == STREAM) || (state_q == DRAIN);
  assign hs          = data_tvalid && data_tready;
  // read_done counts as seen in the very cycle it arrives
  assign rd_any      = rd_seen_q || read_done;
  assign last_beat   = (beat_q == len_q - 16'd1);
  assign addr_sum    = buf_start_q + beat_q;
  assign bank_mask   = bcast_q ? {NUM_BANKS{1'b1}} : (NUM_BANKS'(1) << bank_q);

  always_comb begin
    state_d      = state_q;
    buf_start_d  = buf_start_q;
    len_d        = len_q;
    beat_d       = beat_q;
    bank_d       = bank_q;
    bcast_d      = bcast_q;
    rd_seen_d    = rd_seen_q;
    err_d        = err_q;
    xaddr_d      = xaddr_q;
    xsize_d      = xsize_q;
    read_start_d = 1'b0;
    ap_done_d    = 1'b0;
    wr_valid_d   = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          buf_start_d = ctrl_instruction[47:32];
          len_d       = ctrl_instruction[63:48];
          bank_d      = ctrl_instruction[24 +: BW];
          bcast_d     = ctrl_instruction[23];
          xaddr_d     = ctrl_addr_offset + ADDR_WIDTH'(ctrl_instruction[79:64]);
          xsize_d     = XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
          beat_d      = '0;
          rd_seen_d   = 1'b0;
          err_d       = '0;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        if (len_q == 16'd0) begin
          state_d = DONE;
        end else begin
          read_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        rd_seen_d = rd_any;
        state_d   = STREAM;
      end
      STREAM: begin
        rd_seen_d = rd_any;
        if (hs) begin
          wr_valid_d = bank_mask;
          wr_addr_d  = BUF_AW'(addr_sum);
          wr_data_d  = data_tdata;
          if (last_beat) begin
            state_d = rd_any ? DONE : DRAIN;
          end else begin
            beat_d = beat_q + 16'd1;
            if (rd_any) begin
              err_d[1] = 1'b1;
              state_d  = DONE;
            end else if (data_tlast) begin
              err_d[1] = 1'b1;
              state_d  = DRAIN;
            end
          end
        end else if (rd_any) begin
          err_d[1] = 1'b1;
          state_d  = DONE;
        end
      end
      DRAIN: begin
        rd_seen_d = rd_any;
        if (hs) err_d[0] = 1'b1;
        if (rd_any) state_d = DONE;
      end
      DONE: begin
        ap_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q      <= IDLE;
      buf_start_q  <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      bank_q       <= '0;
      bcast_q      <= 1'b0;
      rd_seen_q    <= 1'b0;
      err_q        <= '0;
      xaddr_q      <= '0;
      xsize_q      <= '0;
      read_start_q <= 1'b0;
      ap_done_q    <= 1'b0;
      wr_valid_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      buf_start_q  <= buf_start_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      bank_q       <= bank_d;
      bcast_q      <= bcast_d;
      rd_seen_q    <= rd_seen_d;
      err_q        <= err_d;
      xaddr_q      <= xaddr_d;
      xsize_q      <= xsize_d;
      read_start_q <= read_start_d;
      ap_done_q    <= ap_done_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign ap_done                 = ap_done_q;
  assign read_start              = read_start_q;
  assign dram_xfer_start_addr    = xaddr_q;
  assign dram_xfer_size_in_bytes = xsize_q;
  assign buf_wr_valid            = wr_valid_q;
  assign buf_wr_addr             = wr_addr_q;
  assign buf_wr_data             = wr_data_q;
  assign err_status              = err_q;

endmodule

// File: tb/tb_gnn_0_bias_loader_mb.sv
// Randomized self-checking bench for gnn_0_bias_loader_mb; expected writes and
// flags come from a transaction-level model of the loader's rules.
module tb_gnn_0_bias_loader_mb;

  logic         kernel_clk = 1'b0;
  logic         kernel_rst;
  logic         ap_start;
  logic         ap_done;
  logic [63:0]  ctrl_addr_offset;
  logic [95:0]  ctrl_instruction;
  logic [63:0]  dram_xfer_start_addr;
  logic [31:0]  dram_xfer_size_in_bytes;
  logic         read_start;
  logic         read_done;
  logic         data_tvalid;
  logic         data_tready;
  logic         data_tlast;
  logic [511:0] data_tdata;
  logic [3:0]   buf_wr_valid;
  logic [8:0]   buf_wr_addr;
  logic [511:0] buf_wr_data;
  logic [1:0]   err_status;

  gnn_0_bias_loader_mb dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
    .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .dram_xfer_start_addr(dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
    .read_start(read_start), .read_done(read_done),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .data_tlast(data_tlast), .data_tdata(data_tdata),
    .buf_wr_valid(buf_wr_valid), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .err_status(err_status)
  );

  always #5 kernel_clk = ~kernel_clk;

  typedef struct {
    logic [8:0]   a;
    logic [511:0] d;
    logic [3:0]   v;
  } wr_t;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           rs_cnt, rs_cyc, done_cnt, done_cyc;
  wr_t          obs_q[$];
  logic [511:0] sent_q[$];

  // Observe outputs just after each rising edge; cyc numbers the cycle
  always @(posedge kernel_clk) begin
    #1;
    cyc++;
    if (!kernel_rst) begin
      if (buf_wr_valid != 4'b0) obs_q.push_back('{buf_wr_addr, buf_wr_data, buf_wr_valid});
      if (read_start) begin rs_cnt++; rs_cyc = cyc; end
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  function automatic logic [511:0] rand_beat();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // Drive one instruction, a contiguous stream of n beats (tlast on beat tl,
  // tl<0 for none), then read_done; check against the transaction model.
  task automatic run_txn(input string nm, input logic [63:0] off, input logic [15:0] bstart,
                         input logic [15:0] len, input logic [15:0] dstart, input logic [15:0] blen,
                         input logic [1:0] bank, input logic bc, input int n, input int tl);
    int          c0, guard, sent, exp_wr;
    logic        short_tl, exp_e0, exp_e1;
    logic [1:0]  exp_err;
    logic [3:0]  exp_v;
    logic [8:0]  exp_a;
    logic [511:0] beat;
    logic [95:0] inst;

    @(negedge kernel_clk);
    obs_q.delete(); sent_q.delete();
    rs_cnt = 0; done_cnt = 0; rs_cyc = -1; done_cyc = -1;
    inst = '0;
    inst[47:32] = bstart; inst[63:48] = len; inst[79:64] = dstart;
    inst[95:80] = blen;   inst[25:24] = bank; inst[23] = bc;
    ap_start = 1'b1; ctrl_addr_offset = off; ctrl_instruction = inst;
    c0 = cyc;
    @(negedge kernel_clk);
    ap_start = 1'b0;

    if (len != 16'd0) begin
      guard = 0;
      while (rs_cnt == 0 && guard < 10) begin @(negedge kernel_clk); guard++; end
      checks++;
      if (rs_cyc != c0 + 2) begin
        errors++; $display("[TB] FAIL %s read_start_cycle: got %0d want %0d", nm, rs_cyc - c0, 2);
      end
      checks++;
      if (dram_xfer_start_addr !== off + {48'b0, dstart}) begin
        errors++; $display("[TB] FAIL %s dram_addr: got %h want %h", nm, dram_xfer_start_addr, off + {48'b0, dstart});
      end
      checks++;
      if (dram_xfer_size_in_bytes !== {16'b0, blen}) begin
        errors++; $display("[TB] FAIL %s dram_size: got %h want %h", nm, dram_xfer_size_in_bytes, blen);
      end
      sent = 0; guard = 0; beat = rand_beat();
      while (sent < n && guard < 200) begin
        data_tvalid = 1'b1; data_tdata = beat; data_tlast = (sent == tl);
        if (data_tready) begin sent_q.push_back(beat); sent++; beat = rand_beat(); end
        @(negedge kernel_clk); guard++;
      end
      data_tvalid = 1'b0; data_tlast = 1'b0;
      @(negedge kernel_clk);
      read_done = 1'b1;
      @(negedge kernel_clk);
      read_done = 1'b0;
    end

    guard = 0;
    while (done_cnt == 0 && guard < 30) begin @(negedge kernel_clk); guard++; end
    repeat (4) @(negedge kernel_clk);

    checks++;
    if (done_cnt != 1) begin
      errors++; $display("[TB] FAIL %s ap_done_count: got %0d want 1", nm, done_cnt);
    end
    if (len == 16'd0) begin
      checks++;
      if (done_cyc != c0 + 3) begin
        errors++; $display("[TB] FAIL %s ap_done_cycle: got %0d want 3", nm, done_cyc - c0);
      end
      checks++;
      if (rs_cnt != 0) begin
        errors++; $display("[TB] FAIL %s read_start_count: got %0d want 0", nm, rs_cnt);
      end
    end

    // Transaction model: early tlast truncates, missing beats are short,
    // anything accepted after the written beats is an overrun
    short_tl = (len != 0) && (tl >= 0) && (tl < int'(len) - 1) && (tl < n);
    if (len == 0)      exp_wr = 0;
    else if (short_tl) exp_wr = tl + 1;
    else               exp_wr = (n < int'(len)) ? n : int'(len);
    exp_e1  = (len != 0) && (short_tl || n < int'(len));
    exp_e0  = (len != 0) && (n > exp_wr);
    exp_err = {exp_e1, exp_e0};
    exp_v   = bc ? 4'b1111 : (4'b0001 << bank);

    checks++;
    if (obs_q.size() != exp_wr) begin
      errors++; $display("[TB] FAIL %s write_count: got %0d want %0d", nm, obs_q.size(), exp_wr);
    end
    for (int i = 0; i < exp_wr && i < obs_q.size(); i++) begin
      exp_a = 9'((int'(bstart) + i) % 512);
      checks++;
      if (obs_q[i].a !== exp_a || obs_q[i].v !== exp_v || obs_q[i].d !== sent_q[i]) begin
        errors++;
        $display("[TB] FAIL %s write[%0d]: got addr=%0d valid=%b data_lo=%h want addr=%0d valid=%b data_lo=%h",
                 nm, i, obs_q[i].a, obs_q[i].v, obs_q[i].d[31:0], exp_a, exp_v, sent_q[i][31:0]);
      end
    end
    checks++;
    if (err_status !== exp_err) begin
      errors++; $display("[TB] FAIL %s err_status: got %b want %b", nm, err_status, exp_err);
    end
  endtask

  task automatic test_reset();
    kernel_rst = 1'b1; ap_start = 1'b1; data_tvalid = 1'b1; data_tlast = 1'b1;
    data_tdata = rand_beat(); read_done = 1'b1;
    repeat (3) @(negedge kernel_clk);
    checks++;
    if ({ap_done, read_start, data_tready, buf_wr_valid, buf_wr_addr, err_status} !== '0 ||
        buf_wr_data !== '0 || dram_xfer_start_addr !== '0 || dram_xfer_size_in_bytes !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got done=%b rs=%b rdy=%b v=%b a=%0d err=%b addr=%h size=%h want all zero",
               ap_done, read_start, data_tready, buf_wr_valid, buf_wr_addr, err_status,
               dram_xfer_start_addr, dram_xfer_size_in_bytes);
    end
    ap_start = 1'b0; data_tvalid = 1'b0; data_tlast = 1'b0; read_done = 1'b0;
    kernel_rst = 1'b0;
    repeat (2) @(negedge kernel_clk);
  endtask

  task automatic test_nominal();
    run_txn("nominal", 64'h1000, 16'd10, 16'd4, 16'h40, 16'd256, 2'd2, 1'b0, 4, -1);
  endtask

  task automatic test_wrap_broadcast();
    run_txn("wrap_bcast", 64'h2000, 16'd510, 16'd4, 16'h80, 16'd256, 2'd1, 1'b1, 4, -1);
  endtask

  task automatic test_zero_length();
    run_txn("zero_len", 64'h3000, 16'd5, 16'd0, 16'h10, 16'd0, 2'd0, 1'b0, 0, -1);
  endtask

  task automatic test_overrun();
    run_txn("overrun", 64'h4000, 16'd20, 16'd2, 16'h0, 16'd128, 2'd3, 1'b0, 3, -1);
  endtask

  task automatic test_short_tlast();
    run_txn("short_tlast", 64'h5000, 16'd30, 16'd4, 16'h100, 16'd256, 2'd0, 1'b0, 2, 1);
  endtask

  task automatic test_short_read_done();
    run_txn("short_rdone", 64'h6000, 16'd40, 16'd5, 16'h20, 16'd320, 2'd1, 1'b0, 3, -1);
  endtask

  task automatic test_reset_mid_stream();
    int guard;
    @(negedge kernel_clk);
    obs_q.delete(); rs_cnt = 0; done_cnt = 0;
    ctrl_addr_offset = 64'h1000;
    ctrl_instruction = '0;
    ctrl_instruction[47:32] = 16'd10; ctrl_instruction[63:48] = 16'd4;
    ctrl_instruction[79:64] = 16'h40; ctrl_instruction[25:24] = 2'd2;
    ap_start = 1'b1;
    @(negedge kernel_clk);
    ap_start = 1'b0;
    guard = 0;
    while (!data_tready && guard < 10) begin @(negedge kernel_clk); guard++; end
    data_tvalid = 1'b1; data_tdata = rand_beat();
    @(negedge kernel_clk);
    kernel_rst = 1'b1;
    @(negedge kernel_clk);
    checks++;
    if ({ap_done, read_start, data_tready, buf_wr_valid, buf_wr_addr, err_status} !== '0 ||
        buf_wr_data !== '0 || dram_xfer_start_addr !== '0 || dram_xfer_size_in_bytes !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got done=%b rs=%b rdy=%b v=%b a=%0d addr=%h want all zero",
               ap_done, read_start, data_tready, buf_wr_valid, buf_wr_addr, dram_xfer_start_addr);
    end
    obs_q.delete(); done_cnt = 0;
    @(negedge kernel_clk);
    kernel_rst = 1'b0;
    read_done = 1'b1;
    @(negedge kernel_clk);
    read_done = 1'b0;
    repeat (5) @(negedge kernel_clk);
    data_tvalid = 1'b0;
    checks++;
    if (done_cnt != 0 || obs_q.size() != 0 || data_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got ap_done=%0d writes=%0d tready=%b want 0 0 0",
               done_cnt, obs_q.size(), data_tready);
    end
    run_txn("after_reset", 64'h1000, 16'd10, 16'd4, 16'h40, 16'd64, 2'd2, 1'b0, 4, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n, tl;
      logic [15:0] len;
      len = 16'($urandom_range(1, 6));
      n   = $urandom_range(1, 8);
      tl  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
      run_txn($sformatf("rand%0d", it), {$urandom, $urandom}, 16'($urandom_range(0, 65535)),
              len, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              n, tl);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_a", 64'h7000, 16'd100, 16'd3, 16'h8, 16'd192, 2'd3, 1'b0, 3, -1);
    run_txn("b2b_b", 64'h8000, 16'd511, 16'd2, 16'h18, 16'd128, 2'd0, 1'b1, 2, -1);
  endtask

  initial begin
    ap_start = 1'b0; ctrl_addr_offset = '0; ctrl_instruction = '0;
    read_done = 1'b0; data_tvalid = 1'b0; data_tlast = 1'b0; data_tdata = '0;
    kernel_rst = 1'b1;
    test_reset();
    test_nominal();
    test_wrap_broadcast();
    test_zero_length();
    test_overrun();
    test_short_tlast();
    test_short_read_done();
    test_reset_mid_stream();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
